axis_dvp: RTL and testbench
===========================

// Module: axis_dvp
// PURPOSE
//  Transmit side of the DVP link: turns an AXI-Stream pixel stream (tuser=SOF, tlast=EOL) into DVP-style
//  parallel video (vsync/hsync/data), one pixel per clk_i. Used as the camera model that drives dvp_axis
//  in benches, and as a parallel video output of the pipeline. Generates frame timing and absorbs stalls.
// PARAMETERS
//  WIDTH_P    8    pixel width, bits
//  LINE_W_P   640  active pixels per line
//  FRAME_H_P  480  active lines per frame
//  HBLANK_P   16   hsync-low cycles after each line (>=1)
//  VSYNC_P    8    vsync-high cycles at frame start (>=1)
//  VBP_P      8    blank cycles between vsync fall and first line (>=1)
// PORTS
//  clk_i         in   1        pixel clock; all logic rising-edge
//  rstn_i        in   1        asynchronous active-low reset
//  tdata_i       in   WIDTH_P  axis pixel
//  tuser_i       in   1        axis start of frame
//  tlast_i       in   1        axis end of line
//  tvalid_i      in   1        axis valid
//  tready_o      out  1        axis ready
//  vsync_o       out  1        frame sync, active high
//  hsync_o       out  1        line valid, active high (DVP href)
//  data_o        out  WIDTH_P  pixel; meaningful only while hsync_o=1
//  frame_done_o  out  1        1-cycle pulse after last HBLANK of a frame
//  underrun_o    out  1        1-cycle pulse: active pixel slot with no valid beat
//  err_o         out  1        1-cycle pulse: framing error
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; counters 0. Reset mid-frame aborts output immediately.
//  All DVP outputs registered; beat accepted in cycle N appears on data_o/hsync_o in N+1.
//  States: IDLE -> VSYNC -> VBP -> ACTIVE <-> HBLANK -> IDLE.
//  IDLE: tready_o = tvalid_i & ~tuser_i (non-SOF beats drained/dropped); tvalid_i&tuser_i -> VSYNC, beat not consumed.
//  VSYNC: vsync_o=1 for VSYNC_P cycles, tready_o=0 -> VBP. VBP: VBP_P cycles all low -> ACTIVE, row=0, col=0.
//  ACTIVE: exactly LINE_W_P cycles, hsync_o=1, tready_o=1, col increments every cycle regardless of tvalid_i.
//   tvalid_i=0 in a slot: data_o=0, underrun_o pulse; line length never shrinks (DVP cannot stall).
//   col==LINE_W_P-1 -> HBLANK. HBLANK: HBLANK_P cycles hsync_o=0, tready_o=0; then row++ ->
//   ACTIVE, or if row==FRAME_H_P-1 -> IDLE with frame_done_o pulse.
//  err_o (data still output, timing unaffected): accepted beat with tlast_i=1 at col!=LINE_W_P-1; accepted beat
//   with tlast_i=0 at col==LINE_W_P-1; accepted beat with tuser_i=1 other than row0/col0.
//  Simultaneous underrun and col==LINE_W_P-1: underrun_o pulses, no err_o, still -> HBLANK.
//  Counters: col $clog2(LINE_W_P), row $clog2(FRAME_H_P), blank counter sized to max(HBLANK_P,VSYNC_P,VBP_P); wrap only via FSM.
// CONFIGURATION
//  AXIS_DVP_TESTPAT_EN defined: extra input pattern_i (1 bit). pattern_i=1 sampled in IDLE starts a frame without
//   waiting for tuser; data_o = (col ^ row) low WIDTH_P bits; tready_o=0 throughout; no underrun_o/err_o.
//  Not defined: port absent, stream-only behaviour above.
// STRUCTURE
//  Package axis_dvp_pkg: state enum (IDLE,VSYNC,VBP,ACTIVE,HBLANK), counter-width helper function.
//  Sub-module dvp_timing: FSM + counters producing hsync/vsync/col/row/frame_done; axis_dvp adds handshake, data mux, checks.
// TESTING (LINE_W_P=4, FRAME_H_P=2, HBLANK_P=2, VSYNC_P=3, VBP_P=2)
//  Full frame 8 beats 1..8, tvalid=1 -> vsync 3 cycles, 2 blank, hsync 4 high/2 low x2, data 1,2,3,4 then 5..8, frame_done 1 pulse.
//  Tvalid=0 at 3rd slot of line 0 -> data_o=0 there, underrun_o 1 pulse, hsync still 4 cycles, next beat lands in slot 4.
//  Beats without tuser in IDLE -> all consumed, no vsync; later tuser beat -> frame starts, tuser beat is pixel 0.
//  tlast on 2nd beat -> err_o pulse at that beat, line still 4 pixels; tuser on row1 col0 -> err_o pulse.
//  Assert rstn_i mid-ACTIVE -> all outputs 0 same edge, tready_o=0, restart needs fresh tuser.
//  With AXIS_DVP_TESTPAT_EN, pattern_i=1 -> frame with row0 data 0,1,2,3 and row1 1,0,3,2; tready_o never 1.

Source files
------------

// File: rtl/axis_dvp_pkg.sv
// Shared types and sizing helpers for the AXI-Stream to DVP transmitter.
package axis_dvp_pkg;

   typedef enum logic [2:0] {
      IDLE,
      VSYNC,
      VBP,
      ACTIVE,
      HBLANK
   } dvp_state_e;

   // Width of a counter that must hold 0..n-1; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/axis_dvp_if.sv
// AXI-Stream pixel channel (tuser = start of frame, tlast = end of line).
interface axis_dvp_if #(
   parameter int WIDTH_P = 8
);
   logic [WIDTH_P-1:0] tdata;
   logic               tuser;
   logic               tlast;
   logic               tvalid;
   logic               tready;

   modport master (output tdata, tuser, tlast, tvalid, input tready);
   modport slave  (input tdata, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_dvp_timing.sv
// DVP frame timing: sequencing FSM, pixel/line counters, registered sync strobes.
//
// state  | meaning
// IDLE   | waiting for a frame start request
// VSYNC  | vsync high, VSYNC_P cycles
// VBP    | vertical back porch, VBP_P cycles all low
// ACTIVE | one pixel slot per cycle, LINE_W_P slots per line
// HBLANK | hsync low HBLANK_P cycles; next line or end of frame
module dvp_timing
   import axis_dvp_pkg::*;
#(
   parameter int LINE_W_P  = 640,
   parameter int FRAME_H_P = 480,
   parameter int HBLANK_P  = 16,
   parameter int VSYNC_P   = 8,
   parameter int VBP_P     = 8
)(
   input  logic                            clk_i,
   input  logic                            rstn_i,
   input  logic                            start_i,
   output dvp_state_e                      state_o,
   output logic [cnt_w(LINE_W_P)-1:0]      col_o,
   output logic [cnt_w(FRAME_H_P)-1:0]     row_o,
   output logic                            vsync_o,
   output logic                            hsync_o,
   output logic                            frame_done_o
);
   localparam int COL_W = cnt_w(LINE_W_P);
   localparam int ROW_W = cnt_w(FRAME_H_P);
   localparam int BLK_W = cnt_w(max3(HBLANK_P, VSYNC_P, VBP_P));
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_W_P - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FRAME_H_P - 1);

   dvp_state_e       state_q, state_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [BLK_W-1:0] blk_q, blk_d;
   logic             vsync_q, vsync_d;
   logic             hsync_q, hsync_d;
   logic             done_q, done_d;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= IDLE;
         col_q   <= '0;
         row_q   <= '0;
         blk_q   <= '0;
         vsync_q <= 1'b0;
         hsync_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         blk_q   <= blk_d;
         vsync_q <= vsync_d;
         hsync_q <= hsync_d;
         done_q  <= done_d;
      end
   end

   // Blank phases use one shared down-counter loaded on entry, exit at zero.
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      blk_d   = blk_q;
      done_d  = 1'b0;
      vsync_d = (state_q == VSYNC);
      hsync_d = (state_q == ACTIVE);
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = VSYNC;
               blk_d   = BLK_W'(VSYNC_P - 1);
            end
         end
         VSYNC: begin
            if (blk_q == '0) begin
               state_d = VBP;
               blk_d   = BLK_W'(VBP_P - 1);
            end else begin
               blk_d = blk_q - 1'b1;
            end
         end
         VBP: begin
            if (blk_q == '0) begin
               state_d = ACTIVE;
               col_d   = '0;
               row_d   = '0;
            end else begin
               blk_d = blk_q - 1'b1;
            end
         end
         ACTIVE: begin
            if (col_q == COL_LAST) begin
               state_d = HBLANK;
               col_d   = '0;
               blk_d   = BLK_W'(HBLANK_P - 1);
            end else begin
               col_d = col_q + 1'b1;
            end
         end
         HBLANK: begin
            if (blk_q == '0) begin
               if (row_q == ROW_LAST) begin
                  state_d = IDLE;
                  row_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  state_d = ACTIVE;
                  row_d   = row_q + 1'b1;
               end
            end else begin
               blk_d = blk_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign state_o      = state_q;
   assign col_o        = col_q;
   assign row_o        = row_q;
   assign vsync_o      = vsync_q;
   assign hsync_o      = hsync_q;
   assign frame_done_o = done_q;
endmodule

// File: rtl/axis_dvp.sv
// AXI-Stream to DVP transmitter: handshake, pixel mux and framing checks around dvp_timing.
// Define AXIS_DVP_TESTPAT_EN to add pattern_i, a built-in (col ^ row) test pattern source.
module axis_dvp
   import axis_dvp_pkg::*;
#(
   parameter int WIDTH_P   = 8,
   parameter int LINE_W_P  = 640,
   parameter int FRAME_H_P = 480,
   parameter int HBLANK_P  = 16,
   parameter int VSYNC_P   = 8,
   parameter int VBP_P     = 8
)(
   input  logic               clk_i,
   input  logic               rstn_i,
   axis_dvp_if.slave          s_axis,
`ifdef AXIS_DVP_TESTPAT_EN
   input  logic               pattern_i,
`endif
   output logic               vsync_o,
   output logic               hsync_o,
   output logic [WIDTH_P-1:0] data_o,
   output logic               frame_done_o,
   output logic               underrun_o,
   output logic               err_o
);
   localparam int COL_W = cnt_w(LINE_W_P);
   localparam int ROW_W = cnt_w(FRAME_H_P);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_W_P - 1);

   dvp_state_e         state;
   logic [COL_W-1:0]   col;
   logic [ROW_W-1:0]   row;
   logic               start;
   logic               tready;
   logic               pat_start;
   logic               pat_mode;
   logic [WIDTH_P-1:0] pat_px;
   logic [WIDTH_P-1:0] data_q, data_d;
   logic               underrun_q, underrun_d;
   logic               err_q, err_d;
   logic               at_eol;
   logic               at_sof;

   dvp_timing #(
      .LINE_W_P  (LINE_W_P),
      .FRAME_H_P (FRAME_H_P),
      .HBLANK_P  (HBLANK_P),
      .VSYNC_P   (VSYNC_P),
      .VBP_P     (VBP_P)
   ) u_timing (
      .clk_i        (clk_i),
      .rstn_i       (rstn_i),
      .start_i      (start),
      .state_o      (state),
      .col_o        (col),
      .row_o        (row),
      .vsync_o      (vsync_o),
      .hsync_o      (hsync_o),
      .frame_done_o (frame_done_o)
   );

`ifdef AXIS_DVP_TESTPAT_EN
   localparam int PW = max3(COL_W, ROW_W, WIDTH_P);
   logic pat_q, pat_d;

   // Mode is latched at the frame start and held until the FSM returns to IDLE.
   assign pat_d     = (state == IDLE) ? pattern_i : pat_q;
   assign pat_start = pattern_i;
   assign pat_mode  = pat_q;
   assign pat_px    = WIDTH_P'(PW'(col) ^ PW'(row));

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) pat_q <= 1'b0;
      else         pat_q <= pat_d;
   end
`else
   assign pat_start = 1'b0;
   assign pat_mode  = 1'b0;
   assign pat_px    = '0;
`endif

   assign at_eol = (col == COL_LAST);
   assign at_sof = (col == '0) && (row == '0);

   // ACTIVE slots never wait for the stream: a missing beat becomes a zero pixel.
   always_comb begin
      tready     = 1'b0;
      start      = 1'b0;
      data_d     = '0;
      underrun_d = 1'b0;
      err_d      = 1'b0;
      case (state)
         IDLE: begin
            start  = pat_start | (s_axis.tvalid & s_axis.tuser);
            tready = s_axis.tvalid & ~s_axis.tuser & ~pat_start;
         end
         ACTIVE: begin
            tready = ~pat_mode;
            if (pat_mode) begin
               data_d = pat_px;
            end else if (s_axis.tvalid) begin
               data_d = s_axis.tdata;
               err_d  = (s_axis.tlast ^ at_eol) | (s_axis.tuser & ~at_sof);
            end else begin
               underrun_d = 1'b1;
            end
         end
         default: ;
      endcase
      tready = tready & rstn_i;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         data_q     <= '0;
         underrun_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         data_q     <= data_d;
         underrun_q <= underrun_d;
         err_q      <= err_d;
      end
   end

   assign s_axis.tready = tready;
   assign data_o        = data_q;
   assign underrun_o    = underrun_q;
   assign err_o         = err_q;
endmodule

// File: tb/tb_axis_dvp.sv
// Self-checking bench for axis_dvp: per-cycle comparison against a frame-timeline reference model.
`timescale 1ns/1ps
module tb_axis_dvp;
   localparam int WD  = 8;
   localparam int W   = 4;
   localparam int H   = 2;
   localparam int HB  = 2;
   localparam int VS  = 3;
   localparam int VBP = 2;
   localparam int L   = 1 + VS + VBP + H * (W + HB);
   localparam int K_IDLE = 0, K_VS = 1, K_VBP = 2, K_ACT = 3, K_HB = 4;

   logic          clk_i  = 1'b0;
   logic          rstn_i = 1'b0;
   logic          vsync_o, hsync_o, frame_done_o, underrun_o, err_o;
   logic [WD-1:0] data_o;
`ifdef AXIS_DVP_TESTPAT_EN
   logic          pattern_i = 1'b0;
`endif

   axis_dvp_if #(.WIDTH_P(WD)) s_axis ();

   axis_dvp #(
      .WIDTH_P(WD), .LINE_W_P(W), .FRAME_H_P(H),
      .HBLANK_P(HB), .VSYNC_P(VS), .VBP_P(VBP)
   ) dut (
      .clk_i        (clk_i),
      .rstn_i       (rstn_i),
      .s_axis       (s_axis),
`ifdef AXIS_DVP_TESTPAT_EN
      .pattern_i    (pattern_i),
`endif
      .vsync_o      (vsync_o),
      .hsync_o      (hsync_o),
      .data_o       (data_o),
      .frame_done_o (frame_done_o),
      .underrun_o   (underrun_o),
      .err_o        (err_o)
   );

   always #5 clk_i = ~clk_i;

   // Frame plan: per slot pixel value, tuser, tlast and whether the source has a beat there.
   logic [WD-1:0] bd [H][W];
   bit            bu [H][W];
   bit            bl [H][W];
   bit            bp [H][W];
   bit            pat_run;
   int            n_pass;
   int            n_total;

   // Position of input cycle i (0 = start request) within the frame timeline.
   function automatic void phase(input int i, output int k, output int r, output int c);
      int j;
      k = K_IDLE; r = 0; c = 0;
      if (i <= 0 || i >= L) return;
      if (i <= VS) begin k = K_VS; c = i - 1; return; end
      j = i - 1 - VS;
      if (j < VBP) begin k = K_VBP; c = j; return; end
      j = j - VBP;
      r = j / (W + HB);
      c = j % (W + HB);
      if (c < W) k = K_ACT;
      else begin k = K_HB; c = c - W; end
   endfunction

   task automatic idle_bus();
      s_axis.tvalid = 1'b0;
      s_axis.tuser  = 1'b0;
      s_axis.tlast  = 1'b0;
      s_axis.tdata  = '0;
   endtask

   task automatic drive_beat(input int r, input int c);
      s_axis.tvalid = 1'b1;
      s_axis.tuser  = bu[r][c];
      s_axis.tlast  = bl[r][c];
      s_axis.tdata  = bd[r][c];
   endtask

   task automatic plan(input int mode);
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            bd[r][c] = (mode == 0) ? WD'(r * W + c + 1) : WD'($urandom);
            bu[r][c] = (r == 0 && c == 0);
            bl[r][c] = (c == W - 1);
            bp[r][c] = 1'b1;
            if (mode >= 1 && !(r == 0 && c == 0)) bp[r][c] = ($urandom_range(0, 3) != 0);
            if (mode == 2) begin
               if ($urandom_range(0, 7) == 0) bl[r][c] = !bl[r][c];
               if (!(r == 0 && c == 0) && $urandom_range(0, 9) == 0) bu[r][c] = 1'b1;
            end
         end
      end
   endtask

   // Runs one frame from its start request; stop_at >= 0 abandons it at that cycle.
   task automatic run_frame(input int stop_at);
      int k, r, c, pk, pr, pc;
      logic [WD-1:0] ed;
      logic evs, ehs, efd, eur, eer, etr;
      logic [WD+5:0] exp_v, act_v;
      for (int i = 0; i <= L; i++) begin
         if (i == stop_at) return;
         phase(i, k, r, c);
         idle_bus();
`ifdef AXIS_DVP_TESTPAT_EN
         pattern_i = pat_run && (i == 0);
`endif
         if (!pat_run) begin
            case (k)
               K_IDLE:        if (i == 0) drive_beat(0, 0);
               K_VS, K_VBP:   drive_beat(0, 0);
               K_ACT:         if (bp[r][c]) drive_beat(r, c);
               K_HB:          if (r + 1 < H && bp[r + 1][0]) drive_beat(r + 1, 0);
               default: ;
            endcase
         end
         phase(i - 1, pk, pr, pc);
         evs = (pk == K_VS);
         ehs = (pk == K_ACT);
         efd = (pk == K_HB) && (pr == H - 1) && (pc == HB - 1);
         ed = '0; eur = 1'b0; eer = 1'b0;
         if (pk == K_ACT) begin
            if (pat_run) ed = WD'(pc ^ pr);
            else if (bp[pr][pc]) begin
               ed  = bd[pr][pc];
               eer = (bl[pr][pc] != (pc == W - 1)) || (bu[pr][pc] && !(pr == 0 && pc == 0));
            end else eur = 1'b1;
         end
         etr = (k == K_ACT) && !pat_run;
         @(negedge clk_i);
         act_v = {vsync_o, hsync_o, data_o, frame_done_o, underrun_o, err_o, s_axis.tready};
         exp_v = {evs, ehs, ed, efd, eur, eer, etr};
         n_total++;
         if (act_v !== exp_v)
            $display("FAIL frame cycle %0d {vs,hs,data,fd,ur,err,rdy}: got %b expected %b", i, act_v, exp_v);
         else n_pass++;
         @(posedge clk_i); #1;
      end
   endtask

   task automatic test_reset();
      idle_bus();
      s_axis.tvalid = 1'b1;
      s_axis.tdata  = 8'h5a;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      n_total++;
      if ({vsync_o, hsync_o, data_o, frame_done_o, underrun_o, err_o, s_axis.tready} !== '0)
         $display("FAIL reset_state: got vs=%b hs=%b data=%h fd=%b ur=%b err=%b rdy=%b required all 0",
                  vsync_o, hsync_o, data_o, frame_done_o, underrun_o, err_o, s_axis.tready);
      else n_pass++;
      rstn_i = 1'b1;
      idle_bus();
      @(posedge clk_i); #1;
   endtask

   task automatic test_idle_drain();
      for (int n = 0; n < 5; n++) begin
         idle_bus();
         s_axis.tvalid = 1'b1;
         s_axis.tlast  = 1'($urandom);
         s_axis.tdata  = WD'($urandom);
         @(negedge clk_i);
         n_total++;
         if ({vsync_o, hsync_o, s_axis.tready} !== 3'b001)
            $display("FAIL idle_drain %0d: got vs=%b hs=%b rdy=%b required 0 0 1", n, vsync_o, hsync_o, s_axis.tready);
         else n_pass++;
         @(posedge clk_i); #1;
      end
      plan(1);
      run_frame(-1);
   endtask

   task automatic test_reset_mid();
      plan(0);
      run_frame(8);
      idle_bus();
      s_axis.tvalid = 1'b1;
      s_axis.tdata  = 8'hc3;
      #2 rstn_i = 1'b0;
      #1;
      n_total++;
      if ({vsync_o, hsync_o, data_o, frame_done_o, underrun_o, err_o, s_axis.tready} !== '0)
         $display("FAIL reset_mid: got vs=%b hs=%b data=%h fd=%b ur=%b err=%b rdy=%b required all 0",
                  vsync_o, hsync_o, data_o, frame_done_o, underrun_o, err_o, s_axis.tready);
      else n_pass++;
      @(negedge clk_i); #1 rstn_i = 1'b1;
      @(posedge clk_i); #1;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk_i);
         n_total++;
         if ({vsync_o, hsync_o, data_o, s_axis.tready} !== {2'b00, {WD{1'b0}}, 1'b1})
            $display("FAIL reset_restart %0d: got vs=%b hs=%b data=%h rdy=%b required 0 0 00 1",
                     n, vsync_o, hsync_o, data_o, s_axis.tready);
         else n_pass++;
         @(posedge clk_i); #1;
      end
      idle_bus();
      plan(1);
      run_frame(-1);
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      pat_run = 1'b0;
      idle_bus();
      test_reset();
      // full frame, pixels 1..8
      plan(0);
      run_frame(-1);
      // underrun at third slot of line 0
      plan(0);
      bp[0][2] = 1'b0;
      run_frame(-1);
      test_idle_drain();
      // framing errors: early tlast and a stray tuser at row 1 col 0
      plan(0);
      bl[0][1] = 1'b1;
      bu[1][0] = 1'b1;
      run_frame(-1);
      // back-to-back random frames with gaps and framing errors
      for (int f = 0; f < 6; f++) begin
         plan((f % 2) + 1);
         run_frame(-1);
      end
      test_reset_mid();
`ifdef AXIS_DVP_TESTPAT_EN
      pat_run = 1'b1;
      run_frame(-1);
      pat_run = 1'b0;
      pattern_i = 1'b0;
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
